// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants and S-box lookup
package aes_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] AES_LAST_ROUND = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [0:255][7:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational 32-bit SubWord from four S-box byte lookups
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);
  assign s = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
endmodule

// File: rtl/aes128_key_sched.sv
// aes128_key_sched: iterative AES-128 round key generator with valid/ready output
// AES_KEY_ZEROIZE_EN: clear round_key on the final handshake and keep it zero while idle
module aes128_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         ready,
  output logic         valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         is_final_round,
  output logic         busy,
  output logic         done
);
  state_t state;
  logic [7:0] rcon;
  logic [31:0] sw, t;
  logic [127:0] next_key;
  aes_sub_word u_sub (.w({round_key[23:0], round_key[31:24]}), .s(sw));
  always_comb begin
    t = sw ^ {rcon, 24'h0};
    next_key[127:96] = round_key[127:96] ^ t;
    next_key[95:64] = round_key[95:64] ^ next_key[127:96];
    next_key[63:32] = round_key[63:32] ^ next_key[95:64];
    next_key[31:0] = round_key[31:0] ^ next_key[63:32];
  end
  assign busy = state == RUN;
  assign is_final_round = round_num == AES_LAST_ROUND;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      done <= 1'b0;
      round_key <= '0;
      round_num <= '0;
      rcon <= RCON_INIT;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          round_key <= key_in;
          round_num <= '0;
          rcon <= RCON_INIT;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        if (is_final_round) begin
          state <= IDLE;
          valid <= 1'b0;
          done <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
          round_key <= '0;
`else
          round_key <= round_key;
`endif
        end else begin
          round_key <= next_key;
          round_num <= round_num + 4'd1;
          rcon <= xtime(rcon);
        end
      end
    end
  end
endmodule

// File: tb/tb_aes128_key_sched.sv
// tb_aes128_key_sched: self-checking bench against a FIPS-197 style key expansion model
module tb_aes128_key_sched;
  logic clk = 0, rst = 1, start = 0, ready = 0;
  logic [127:0] key_in = '0;
  logic valid, is_final_round, busy, done;
  logic [127:0] round_key;
  logic [3:0] round_num;
  int n_pass = 0, n_chk = 0;
  logic [7:0] sb [256];
  logic [127:0] rk [11];
  logic [127:0] got [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;
  vec_t vecs [2];

  aes128_key_sched dut (.clk(clk), .rst(rst), .start(start), .key_in(key_in), .ready(ready),
    .valid(valid), .round_key(round_key), .round_num(round_num),
    .is_final_round(is_final_round), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sched(input logic [127:0] key, input bit rnd, input bit poke);
    int r = 0, cyc = 0;
    bit rdy;
    expand(key);
    start = 1; key_in = key;
    step();
    start = 0; key_in = ~key;
    while (r <= 10 && cyc < 300) begin
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      start = poke && r < 10 && $urandom_range(0, 1) == 1;
      chk("valid", 128'(valid), 1);
      chk("round_num", 128'(round_num), 128'(r));
      chk("round_key", round_key, rk[r]);
      chk("is_final_round", 128'(is_final_round), 128'(r == 10));
      chk("busy", 128'(busy), 1);
      chk("done_low", 128'(done), 0);
      if (rdy) got[r] = round_key;
      step();
      cyc++;
      if (rdy) r++;
    end
    start = 0; ready = 0;
    if (cyc >= 300) chk("timeout", 128'(cyc), 0);
    chk("done_pulse", 128'(done), 1);
    chk("done_valid", 128'(valid), 0);
    chk("done_busy", 128'(busy), 0);
`ifdef AES_KEY_ZEROIZE_EN
    chk("done_key_zero", round_key, '0);
`else
    chk("done_key_hold", round_key, rk[10]);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 128'(valid), 0);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_key"}, round_key, 0);
    chk({tag, "_num"}, 128'(round_num), 0);
    chk({tag, "_final"}, 128'(is_final_round), 0);
  endtask

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    build_sbox();
    repeat (2) step();
    chk_reset("reset");
    rst = 0;
    step();
    chk_reset("idle");
    // back-to-back entries also exercise start during the done cycle
    foreach (vecs[i]) begin
      run_sched(vecs[i].key, 0, 0);
      chk("tbl_r0", got[0], vecs[i].key);
      chk("tbl_r1", got[1], vecs[i].r1);
      chk("tbl_r10", got[10], vecs[i].r10);
    end
    step();
    chk("idle_after_done", 128'(done), 0);
    run_sched(vecs[0].key, 1, 1);
    chk("rnd_r1", got[1], vecs[0].r1);
    chk("rnd_r10", got[10], vecs[0].r10);
    for (int k = 0; k < 4; k++)
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1, k[0]);
    step();
    expand(vecs[0].key);
    start = 1; key_in = vecs[0].key;
    step();
    start = 0; ready = 1;
    repeat (5) step();
    chk("pre_rst_num", 128'(round_num), 5);
    chk("pre_rst_key", round_key, rk[5]);
    #2 rst = 1;
    #1 chk_reset("async_rst");
    step();
    rst = 0; ready = 0;
    chk_reset("rst_hold");
    step();
    chk("rst_no_done", 128'(done), 0);
    run_sched(vecs[1].key, 1, 0);
    chk("restart_r10", got[10], vecs[1].r10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes128_key_sched.md
# aes128_key_sched

Iterative on-the-fly AES-128 key schedule that sits directly upstream of the encryption round stage. It loads a 128-bit cipher key and emits round keys 0..10 one at a time under a valid/ready handshake. Alongside each key it emits the round number and the final-round flag that the round stage consumes. One S-box word substitution per round; no key storage beyond the current round key.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  load key_in and begin a schedule; sampled only in IDLE
- key_in  input  128  cipher key; key_in[127:96] = w0, key_in[31:0] = w3
- ready  input  1  consumer accepts the current round key this cycle
- valid  output  1  round_key/round_num/is_final_round are valid
- round_key  output  128  current round key, same word order as key_in
- round_num  output  4  0..10
- is_final_round  output  1  high when round_num == 10
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after round 10 is accepted

## Operation
- States: IDLE, RUN.
- IDLE: valid=0, busy=0. start=1 -> RUN; round_key<=key_in, round_num<=0, rcon<=8'h01, valid<=1.
- RUN: valid=1, busy=1. Handshake = valid && ready.
  - No handshake: all outputs hold.
  - Handshake with round_num<10: round_key<=next key, round_num<=round_num+1, rcon<=xtime(rcon).
  - Handshake with round_num==10: -> IDLE, valid<=0, done<=1 for one cycle.
- Next key: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord(w3) = {w3[23:0],w3[31:24]}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00); rcon sequence 01,02,04,08,10,20,40,80,1B,36.
- is_final_round is combinational from round_num (==10).
- start in RUN is ignored; key_in is sampled only on the accepting start.
- start coincident with done (IDLE cycle) is accepted normally.

## Timing
- Reset values: valid=0, busy=0, done=0, round_key=0, round_num=0, is_final_round=0, rcon=8'h01, state IDLE.
- start sampled at edge N -> valid=1, round_num=0 from edge N onward.
- Each next key is visible one cycle after its handshake; ready held high yields 11 consecutive valid cycles (rounds 0..10).
- done is high in the cycle after the round-10 handshake, with valid=0.
- rst mid-schedule: immediate return to reset values; no done pulse.

## Configuration
- AES_KEY_ZEROIZE_EN defined: round_key is cleared to 128'h0 on the round-10 handshake and held at zero while IDLE.
- AES_KEY_ZEROIZE_EN undefined: round_key retains the round-10 key in IDLE until the next start or reset.
- All other behaviour is identical in both builds.

## Structure
- Shared package aes_pkg: state enum (IDLE, RUN), AES_LAST_ROUND = 4'd10, RCON_INIT = 8'h01, RCON_POLY = 8'h1B, AES S-box constant table.
- One sub-module: aes_sub_word. It is a combinational 32-bit SubWord built from four S-box byte lookups.
- The sequencer, rcon register and word XOR chain live in aes128_key_sched.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with ready=1: round 0 = key_in, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. Also check is_final_round=1 only on round 10, and done one cycle later.
- Same key with ready toggled pseudo-randomly: outputs hold while ready=0, the key sequence is identical, and round_num never skips.
- start pulsed while busy with a different key_in: ignored, sequence unchanged. start in the done cycle: new schedule begins and round 0 equals the new key_in.
- All-zero key: round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- rst asserted at round 5: all outputs return to reset values immediately, no done pulse. A subsequent start restarts at round 0.
- With AES_KEY_ZEROIZE_EN: round_key = 0 in the done cycle. Without it: round_key = round-10 value in the done cycle.
